// File: rtl/bnn_weight_loader.sv
// Streams weight bytes from a host into the BNN core as lo/hi nibble strobes,
// then checks a trailing XOR checksum byte. One session per reset.
module bnn_weight_loader #(
  parameter int NUM_NEURONS = 12,
  parameter int NIB_W       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               start,
  input  logic [2*NIB_W-1:0] byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic [NIB_W-1:0]   nib_out,
  output logic               load_en,
  output logic [4:0]         neuron_idx,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    LO,
    HI,
    CHK,
    DONE
  } state_t;

  state_t               state;
  logic [2*NIB_W-1:0]   weight_buf;
  logic [2*NIB_W-1:0]   xor_acc;
  logic                 nibble_phase;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      weight_buf <= '0;
      xor_acc    <= '0;
      neuron_idx <= '0;
      err        <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= WAIT;
            xor_acc <= '0;
          end
        end
        WAIT: begin
          if (byte_valid) begin
            weight_buf <= byte_in;
            xor_acc    <= xor_acc ^ byte_in;
            state      <= LO;
          end
        end
        LO: state <= HI;
        HI: begin
          neuron_idx <= neuron_idx + 5'd1;
          state      <= (neuron_idx == 5'(NUM_NEURONS - 1)) ? CHK : WAIT;
        end
        CHK: begin
          if (byte_valid) begin
            if (byte_in != xor_acc) err <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          // The core's load pointer cannot rewind, so a second session is refused.
          if (start) err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from the state register; ena gates the handshake and
  // strobe so nothing is consumed or strobed while the block is frozen.
  assign nibble_phase = (state == LO) || (state == HI);
  assign load_en      = ena && nibble_phase;
  assign byte_ready   = ena && ((state == WAIT) || (state == CHK));
  assign nib_out      = !load_en        ? '0 :
                        (state == HI)   ? weight_buf[2*NIB_W-1:NIB_W] :
                                          weight_buf[NIB_W-1:0];
  assign busy         = (state == WAIT) || nibble_phase || (state == CHK);
  assign done         = (state == DONE);

endmodule
